fixed_division: RTL and testbench
=================================

// Module: fixed_division
// PURPOSE
//  Iterative signed fixed-point divider, the inverse of fixed_multiplication for the Julia worker.
//  Computes result = a / b in the same Q(INTEGRAL).(FRACTIONAL) two's-complement format.
//  Uses a start/busy/done handshake and a restoring shift-subtract datapath, one quotient bit per clock.
//  Used for reciprocal and scale setup ahead of the per-pixel multiply pipeline.
// PARAMETERS
//  WIDTH       22  total operand/result width (signed)
//  FRACTIONAL  11  fractional bits; INTEGRAL = WIDTH-FRACTIONAL
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      asynchronous reset, active-high
//  start     in   1      request; sampled only in IDLE
//  a         in   WIDTH  signed dividend, captured when start accepted
//  b         in   WIDTH  signed divisor, captured when start accepted
//  busy      out  1      1 while a division is in progress (state != IDLE)
//  done      out  1      one-cycle pulse; result/flags valid from this cycle
//  result    out  WIDTH  signed quotient, held until next done
//  overflow  out  1      quotient saturated (held with result)
//  div_zero  out  1      b was 0 (held with result)
// BEHAVIOUR
//  Reset: state=IDLE. busy=0, done=0, result=0, overflow=0, div_zero=0. All internal registers cleared.
//  States and transitions:
//   IDLE -> CALC on start=1. Registered on that edge:
//    - N = |a| << FRACTIONAL (WIDTH+FRACTIONAL bits)
//    - D = |b| (WIDTH bits, unsigned)
//    - neg = a[MSB]^b[MSB]; zflag = (b==0); iteration count = WIDTH+FRACTIONAL-1
//   CALC: each cycle, shift remainder left by 1 and bring in the next N bit, MSB first.
//    - If remainder >= D: subtract D and set the quotient bit to 1.
//    - Stay in CALC for exactly WIDTH+FRACTIONAL cycles, then go to FIX.
//   FIX -> IDLE: register sign/saturation into result, overflow and div_zero; pulse done=1.
//  Latency: start sampled at edge 0 -> done high after edge WIDTH+FRACTIONAL+1 (34 with defaults).
//   Latency is fixed for all operands, including b=0.
//  Arithmetic:
//   - Magnitude quotient Q is truncated; the signed result rounds toward zero.
//   - neg=0: Q > 2^(WIDTH-1)-1 -> result = 2^(WIDTH-1)-1, overflow=1.
//   - neg=1: Q > 2^(WIDTH-1) -> result = -2^(WIDTH-1), overflow=1.
//     Q == 2^(WIDTH-1) is exact, overflow=0.
//   - Otherwise result = neg ? -Q : Q.
//   - Q == 0 gives result 0 regardless of neg.
//  Boundary cases:
//   - b=0: div_zero=1, overflow=0. result = +max if a >= 0, else -2^(WIDTH-1).
//   - a = -2^(WIDTH-1): its magnitude 2^(WIDTH-1) is handled without wrap.
//   - start while busy: ignored. Operands are not recaptured.
//   - start in the same cycle done=1: accepted, since state is IDLE. Back-to-back throughput is 1 per 35 cycles.
//   - a/b changing after capture: no effect on the running division.
//   - rst mid-operation: immediate return to reset values; no done pulse for the aborted op.
// TESTING  (Q11.11 values; 1.0 = 2048)
//  a=-2048, b=-4096 (-1/-2), start -> done at edge 34: result=1024, overflow=0, div_zero=0
//  a=1024, b=-1024 (0.5/-0.5) -> result=-2048; a=4096, b=6144 -> 1365; a=-4096, b=6144 -> -1365 (truncate toward zero)
//  a=2097151, b=1 -> result=2097151, overflow=1; a=-2097152, b=2048 -> result=-2097152, overflow=0
//  a=-2048, b=0 -> result=-2097152, div_zero=1, latency still 34; next op a=2048, b=2048 clears flags, result=2048
//  start held high 40 cycles with operands changing -> exactly one done at 34; new op starts on the done cycle, done again 35 later
//  rst pulsed 10 cycles into CALC -> busy=0, result=0 immediately, no done; fresh start afterward yields correct result

Source files
------------

// File: rtl/fixed_division.sv
// fixed_division: iterative signed Qm.f divider, result = a / b, one quotient bit per clock
//   clk       in  1      clock, rising edge
//   rst       in  1      asynchronous reset, active-high
//   start     in  1      request, sampled only while idle
//   a         in  WIDTH  signed dividend, captured on accepted start
//   b         in  WIDTH  signed divisor, captured on accepted start
//   busy      out 1      division in progress
//   done      out 1      one-cycle pulse, result/flags valid from this cycle
//   result    out WIDTH  signed quotient, held until next done
//   overflow  out 1      quotient saturated
//   div_zero  out 1      divisor was zero
module fixed_division #(
  parameter int WIDTH = 22,
  parameter int FRACTIONAL = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    div_zero
);
  localparam int NW = WIDTH + FRACTIONAL;
  localparam int CW = $clog2(NW);
  localparam logic [NW-1:0] HALF = NW'(1) << (WIDTH - 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;
  logic [NW-1:0] n, q;
  logic [WIDTH-1:0] d, rem, mag_a, mag_b, res_nx;
  logic [WIDTH:0] rem_sh;
  logic [CW-1:0] cnt;
  logic neg, zflag, ge, ov_nx, sat;
  // magnitudes are taken unsigned so -2^(WIDTH-1) maps to 2^(WIDTH-1) without wrap
  always_comb begin
    mag_a = a[WIDTH-1] ? -a : a;
    mag_b = b[WIDTH-1] ? -b : b;
    rem_sh = {rem, n[NW-1]};
    ge = rem_sh >= {1'b0, d};
    ov_nx = !zflag && (neg ? q > HALF : q >= HALF);
    sat = zflag || ov_nx;
    // saturated value is -2^(WIDTH-1) when negative, 2^(WIDTH-1)-1 otherwise; b=0 leaves neg = sign of a
    res_nx = sat ? {neg, {(WIDTH-1){~neg}}} : neg ? -q[WIDTH-1:0] : q[WIDTH-1:0];
    busy = state != IDLE;
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? CALC : IDLE) :
               state == CALC ? (cnt == '0 ? FIX : CALC) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n <= '0;
      q <= '0;
      d <= '0;
      rem <= '0;
      cnt <= '0;
      neg <= 1'b0;
      zflag <= 1'b0;
      done <= 1'b0;
      result <= '0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        n <= {mag_a, {FRACTIONAL{1'b0}}};
        d <= mag_b;
        neg <= a[WIDTH-1] ^ b[WIDTH-1];
        zflag <= b == '0;
        cnt <= CW'(NW - 1);
        rem <= '0;
        q <= '0;
      end else if (state == CALC) begin
        n <= n << 1;
        // a partial remainder below d always fits back into WIDTH bits
        rem <= ge ? WIDTH'(rem_sh - {1'b0, d}) : rem_sh[WIDTH-1:0];
        q <= {q[NW-2:0], ge};
        cnt <= cnt - 1'b1;
      end else if (state == FIX) begin
        result <= res_nx;
        overflow <= ov_nx;
        div_zero <= zflag;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fixed_division.sv
// tb_fixed_division: vector table plus scoreboard checks for fixed_division
module tb_fixed_division;
  localparam int W = 22;
  localparam int F = 11;
  localparam int LAT = W + F + 1;
  localparam logic signed [W-1:0] MAXV = W'(2**(W-1) - 1);
  localparam logic signed [W-1:0] MINV = W'(2**(W-1));
  typedef struct {
    logic signed [W-1:0] a, b, res;
    logic ov, dz;
  } vec_t;
  typedef struct {
    logic signed [W-1:0] res;
    logic ov, dz;
    int t0;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic signed [W-1:0] a = '0, b = '0, result;
  logic busy, done, overflow, div_zero;
  exp_t sb[$];
  exp_t e;
  vec_t tv[16];
  int cyc = 0, tests = 0, fails = 0;
  fixed_division #(.WIDTH(W), .FRACTIONAL(F)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .overflow(overflow), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input int x, input int y, input int r, input bit ov, input bit dz);
    vec_t v;
    v.a = W'(x);
    v.b = W'(y);
    v.res = W'(r);
    v.ov = ov;
    v.dz = dz;
    return v;
  endfunction
  function automatic vec_t model(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
    vec_t v;
    longint ax, ay, qq;
    bit ng;
    v.a = x;
    v.b = y;
    v.ov = 1'b0;
    v.dz = 1'b0;
    ax = x < 0 ? -longint'(x) : longint'(x);
    ay = y < 0 ? -longint'(y) : longint'(y);
    ng = (x < 0) != (y < 0);
    if (y == 0) begin
      v.dz = 1'b1;
      v.res = x < 0 ? MINV : MAXV;
    end else begin
      qq = (ax << F) / ay;
      if (!ng && qq > longint'(2**(W-1) - 1)) begin
        v.ov = 1'b1;
        v.res = MAXV;
      end else if (ng && qq > longint'(2**(W-1))) begin
        v.ov = 1'b1;
        v.res = MINV;
      end else v.res = W'(ng ? -qq : qq);
    end
    return v;
  endfunction
  task automatic push(input vec_t v);
    sb.push_back('{v.res, v.ov, v.dz, cyc + 1});
  endtask
  always @(negedge clk)
    if (!rst && done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("result", int'(result), int'(e.res));
        chk("overflow", overflow, e.ov);
        chk("div_zero", div_zero, e.dz);
        chk("latency", cyc - e.t0, LAT);
      end
    end
  task automatic wait_drain();
    for (int k = 0; k < LAT + 10 && sb.size() != 0; k++) begin
      @(posedge clk);
      #2;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask
  task automatic run(input vec_t v);
    @(negedge clk);
    a = v.a;
    b = v.b;
    start = 1'b1;
    push(v);
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    wait_drain();
    chk("done_pulse_width", done, 0);
    chk("result_held", int'(result), int'(v.res));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic signed [W-1:0] x, y;
    tv[0]  = mk(-2048, -4096, 1024, 0, 0);
    tv[1]  = mk(1024, -1024, -2048, 0, 0);
    tv[2]  = mk(4096, 6144, 1365, 0, 0);
    tv[3]  = mk(-4096, 6144, -1365, 0, 0);
    tv[4]  = mk(2097151, 1, 2097151, 1, 0);
    tv[5]  = mk(-2097152, 2048, -2097152, 0, 0);
    tv[6]  = mk(-2048, 0, -2097152, 0, 1);
    tv[7]  = mk(2048, 2048, 2048, 0, 0);
    tv[8]  = mk(5, 0, 2097151, 0, 1);
    tv[9]  = mk(0, 0, 2097151, 0, 1);
    tv[10] = mk(0, 100, 0, 0, 0);
    tv[11] = mk(-1, 4096, 0, 0, 0);
    tv[12] = mk(-2097152, 2047, -2097152, 1, 0);
    tv[13] = mk(-2097152, -2048, 2097151, 1, 0);
    tv[14] = mk(2097151, 2097151, 2048, 0, 0);
    tv[15] = mk(-2097152, -2097152, 2048, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", int'(result), 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_div_zero", div_zero, 0);
    rst = 1'b0;
    foreach (tv[i]) run(tv[i]);
    for (int i = 0; i < 6; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      y = y >>> $urandom_range(0, 18);
      run(model(x, y));
    end
    // start held for 40 cycles with operands churning: only edge 0 and the done cycle accept
    @(negedge clk);
    start = 1'b1;
    a = W'(4096);
    b = W'(6144);
    push(mk(4096, 6144, 1365, 0, 0));
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == LAT + 1) begin
        a = W'(-2048);
        b = W'(-4096);
        push(mk(-2048, -4096, 1024, 0, 0));
      end else begin
        a = W'($urandom);
        b = W'($urandom);
      end
    end
    start = 1'b0;
    wait_drain();
    // reset mid-calculation aborts without a done pulse
    @(negedge clk);
    a = W'(6144);
    b = W'(2048);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_result", int'(result), 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    run(mk(6144, 2048, 6144, 0, 0));
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
